// File: rtl/seg_pkg.sv
// Shared constants, slot-state type and BCD-to-segment decode for the scan driver.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    // Active-low segment encodings, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [5:0] AN_OFF = 6'h3F;

    typedef enum logic {
        StBlank,
        StDrive
    } slot_state_e;

    // Non-BCD codes (10..15) show a dash so bad input is visible rather than garbage
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational 4-bit BCD to active-low seven-segment decoder.
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure table lookup; kept as a module so the top has one shared decoder
    always_comb begin
        seg_o = bcd_to_seg(bcd_i);
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a 6-digit common-anode display (hh mm ss).
// All six digits are snapshotted at the start of each frame; each digit slot
// begins with a blanking gap to suppress ghosting. All outputs are registered.
// Optional build macro SEG_DP_BLINK_EN: dp blinks as the hh.mm.ss separators.
module seven_seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter bit          LZ_SUPPRESS  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hr_tens,
    input  logic [3:0] hr_units,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_units,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_units,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp,
    output logic       frame_start
);

    localparam int unsigned DIGIT_TICKS = CLK_HZ / REFRESH_HZ;
    localparam int unsigned CNT_W       = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int unsigned IDX_W       = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [5:0]       AN_LEFT   = 6'b100000;

    // The slot must hold the blank gap plus at least one drive cycle
    if (BLANK_CYCLES + 1 >= DIGIT_TICKS) begin : g_bad_blank_cycles
        $error("BLANK_CYCLES+1 must be less than CLK_HZ/REFRESH_HZ");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       shadow_q [NUM_DIGITS];
    logic [3:0]       shadow_d [NUM_DIGITS];
    logic [3:0]       digits_in [NUM_DIGITS];
    logic [6:0]       seg_q, seg_d;
    logic [5:0]       an_q, an_d;
    logic             dp_q, dp_d;
    logic             frame_start_q, frame_start_d;

    logic             snap;
    logic             lz_blank;
    logic [3:0]       cur_digit;
    logic [6:0]       cur_seg;
    slot_state_e      slot_state;

    // Gather inputs in scan order: index 0 is the leftmost digit
    always_comb begin
        digits_in[0] = hr_tens;
        digits_in[1] = hr_units;
        digits_in[2] = min_tens;
        digits_in[3] = min_units;
        digits_in[4] = sec_tens;
        digits_in[5] = sec_units;
    end

    // Single shared decoder on the currently selected shadow digit
    always_comb begin
        cur_digit = shadow_q[idx_q];
    end

    bcd_to_7seg u_dec (
        .bcd_i (cur_digit),
        .seg_o (cur_seg)
    );

    // Next-state: slot counter, digit index, frame snapshot and registered pin values
    always_comb begin
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        frame_start_d = 1'b0;
        an_d          = AN_OFF;
        seg_d         = SEG_OFF;
        dp_d          = 1'b1;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        // Latch all digits together so a frame never mixes two times
        snap = (idx_q == '0) && (cnt_q == '0);
        if (snap) begin
            shadow_d      = digits_in;
            frame_start_d = 1'b1;
        end

        slot_state = (cnt_q < CNT_BLANK) ? StBlank : StDrive;
        lz_blank   = LZ_SUPPRESS && (idx_q == '0) && (shadow_q[0] == 4'd0);

        case (slot_state)
            StBlank: begin
                an_d  = AN_OFF;
                seg_d = SEG_OFF;
            end
            StDrive: begin
                if (!lz_blank) begin
                    an_d  = ~(AN_LEFT >> idx_q);
                    seg_d = cur_seg;
                end
`ifdef SEG_DP_BLINK_EN
                // Separators after hours and minutes units, lit on even seconds
                if ((idx_q == IDX_W'(1) || idx_q == IDX_W'(3)) &&
                    !shadow_q[NUM_DIGITS-1][0]) begin
                    dp_d = 1'b0;
                end
`endif
            end
            default: begin
                an_d  = AN_OFF;
                seg_d = SEG_OFF;
            end
        endcase
    end

    // State and output registers, asynchronously forced to the dark display on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
            end
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (DIGIT_TICKS=10, BLANK_CYCLES=2).
module tb_seven_seg_scan_driver;

    localparam int TICKS = 10;
    localparam int BLANK = 2;
    localparam int FRAME = 6 * TICKS;

`ifdef SEG_DP_BLINK_EN
    localparam logic DPB = 1'b0;
`else
    localparam logic DPB = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] hr_tens = 4'd1, hr_units = 4'd2, min_tens = 4'd3;
    logic [3:0] min_units = 4'd4, sec_tens = 4'd5, sec_units = 4'd9;
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp;
    logic       frame_start;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .CLK_HZ       (1000),
        .REFRESH_HZ   (100),
        .BLANK_CYCLES (2),
        .LZ_SUPPRESS  (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hr_tens     (hr_tens),
        .hr_units    (hr_units),
        .min_tens    (min_tens),
        .min_units   (min_units),
        .sec_tens    (sec_tens),
        .sec_units   (sec_units),
        .seg         (seg),
        .an          (an),
        .dp          (dp),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [5:0] an;
        logic       dp;
        logic       fs;
    } out_t;

    localparam out_t RESET_OUT = '{seg: 7'h7F, an: 6'h3F, dp: 1'b1, fs: 1'b0};

    typedef struct packed {
        logic [0:5][3:0] d;
        logic [0:5][5:0] an;
        logic [0:5][6:0] seg;
        logic [0:5]      dp;
    } vec_t;

    vec_t vecs [4];
    out_t exp_q [$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [5:0] ref_an(input int s);
        case (s)
            0: return 6'h1F;
            1: return 6'h2F;
            2: return 6'h37;
            3: return 6'h3B;
            4: return 6'h3D;
            default: return 6'h3E;
        endcase
    endfunction

    // Reference model: on each edge, push the outputs the DUT must show after it
    int         m_cnt = 0;
    int         m_idx = 0;
    logic [3:0] m_sh [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    out_t       m_e;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_cnt = 0;
                m_idx = 0;
                for (int i = 0; i < 6; i++) m_sh[i] = 4'd0;
                exp_q.delete();
            end else begin
                m_e = RESET_OUT;
                m_e.fs = (m_idx == 0 && m_cnt == 0);
                if (m_cnt >= BLANK) begin
                    if (!(m_idx == 0 && m_sh[0] == 4'd0)) begin
                        m_e.an  = ref_an(m_idx);
                        m_e.seg = ref_seg(m_sh[m_idx]);
                    end
`ifdef SEG_DP_BLINK_EN
                    if ((m_idx == 1 || m_idx == 3) && !m_sh[5][0]) m_e.dp = 1'b0;
`endif
                end
                exp_q.push_back(m_e);
                if (m_idx == 0 && m_cnt == 0) begin
                    m_sh[0] = hr_tens;  m_sh[1] = hr_units;
                    m_sh[2] = min_tens; m_sh[3] = min_units;
                    m_sh[4] = sec_tens; m_sh[5] = sec_units;
                end
                if (m_cnt == TICKS - 1) begin
                    m_cnt = 0;
                    m_idx = (m_idx == 5) ? 0 : m_idx + 1;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Scoreboard: compare every cycle away from the active edge
    out_t sb_exp;
    out_t sb_got;

    initial begin
        forever begin
            @(negedge clk);
            sb_got = '{seg: seg, an: an, dp: dp, fs: frame_start};
            if (exp_q.size() > 0) begin
                sb_exp = exp_q.pop_front();
                check("scoreboard", 32'(sb_got), 32'(sb_exp));
            end else begin
                check("scoreboard_reset", 32'(sb_got), 32'(RESET_OUT));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic wait_frame(output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            waited++;
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_start_seen", int'(ok), 1);
    endtask

    task automatic advance(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic set_inputs(input logic [0:5][3:0] d);
        hr_tens  = d[0]; hr_units  = d[1]; min_tens  = d[2];
        min_units = d[3]; sec_tens = d[4]; sec_units = d[5];
    endtask

    // Release reset and check the start-up latency of frame_start and the first anode
    task automatic release_and_check(input logic [6:0] first_seg);
        reset = 1'b0;
        @(negedge clk);
        check("rel_fs_pulse", 32'(frame_start), 1);
        check("rel_an_blank0", 32'(an), 32'h3F);
        @(negedge clk);
        check("rel_fs_single", 32'(frame_start), 0);
        check("rel_an_blank1", 32'(an), 32'h3F);
        @(negedge clk);
        check("rel_an_first", 32'(an), 32'h1F);
        check("rel_seg_first", 32'(seg), 32'(first_seg));
    endtask

    int waited;

    initial begin
        vecs[0] = '{d:   '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9},
                    an:  '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                    seg: '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h10},
                    dp:  '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}};
        vecs[1] = '{d:   '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4},
                    an:  '{6'h3F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                    seg: '{7'h7F, 7'h24, 7'h30, 7'h19, 7'h12, 7'h19},
                    dp:  '{1'b1, DPB, 1'b1, DPB, 1'b1, 1'b1}};
        vecs[2] = '{d:   '{4'd12, 4'd0, 4'd5, 4'd9, 4'd5, 4'd5},
                    an:  '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                    seg: '{7'h3F, 7'h40, 7'h12, 7'h10, 7'h12, 7'h12},
                    dp:  '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}};
        vecs[3] = '{d:   '{4'd2, 4'd3, 4'd15, 4'd6, 4'd10, 4'd8},
                    an:  '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                    seg: '{7'h24, 7'h30, 7'h3F, 7'h02, 7'h3F, 7'h00},
                    dp:  '{1'b1, DPB, 1'b1, DPB, 1'b1, 1'b1}};

        // Reset held, then released
        repeat (3) @(negedge clk);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_an", 32'(an), 32'h3F);
        check("reset_dp", 32'(dp), 1);
        check("reset_fs", 32'(frame_start), 0);
        release_and_check(7'h79);

        // Table-driven frames: blank gap and drive value of every slot
        for (int v = 0; v < 4; v++) begin
            set_inputs(vecs[v].d);
            wait_frame(waited);
            if (v > 0) check("frame_period", waited, 1);
            for (int j = 1; j < FRAME; j++) begin
                @(negedge clk);
                if (j % TICKS == 1) begin
                    check("slot_blank_an", 32'(an), 32'h3F);
                    check("slot_blank_seg", 32'(seg), 32'h7F);
                end else if (j % TICKS == 5) begin
                    check("slot_an", 32'(an), 32'(vecs[v].an[j / TICKS]));
                    check("slot_seg", 32'(seg), 32'(vecs[v].seg[j / TICKS]));
                    check("slot_dp", 32'(dp), 32'(vecs[v].dp[j / TICKS]));
                end
            end
        end

        // Mid-frame input change is deferred to the next frame
        set_inputs(vecs[0].d);
        wait_frame(waited);
        advance(2 * TICKS);
        min_units = 4'd7;
        advance(15);
        check("midframe_old_an", 32'(an), 32'h3B);
        check("midframe_old_seg", 32'(seg), 32'h19);
        wait_frame(waited);
        check("midframe_period", waited, FRAME - 35);
        advance(35);
        check("midframe_new_seg", 32'(seg), 32'h78);

        // Asynchronous reset at cnt=5 of idx=3, then a fresh start with new digits
        wait_frame(waited);
        advance(35);
        check("prereset_an", 32'(an), 32'h3B);
        #1;
        reset = 1'b1;
        #1;
        check("async_seg", 32'(seg), 32'h7F);
        check("async_an", 32'(an), 32'h3F);
        check("async_dp", 32'(dp), 1);
        check("async_fs", 32'(frame_start), 0);
        hr_tens = 4'd4;
        repeat (2) @(negedge clk);
        release_and_check(7'h19);
        advance(FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
